// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response channel shared by the core ports and the bus side.
interface sram_bus_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              uncached;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    // Requester side: issues the transaction, receives handshakes and read data.
    modport master (
        output req, wr, size, addr, wdata, uncached,
        input  addr_ok, data_ok, rdata
    );

    // Responder side: accepts the transaction, returns handshakes and read data.
    modport slave (
        input  req, wr, size, addr, wdata, uncached,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the instruction-fetch and data ports,
// with fixed kseg0/kseg1 translation and one transaction in flight.
module sram_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_bus_arbiter_if.slave  inst,
    sram_bus_arbiter_if.slave  data,
    sram_bus_arbiter_if.master bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    state_t             state,      state_nxt;
    owner_t             owner,      owner_nxt;
    logic [CNT_W-1:0]   starve_cnt, starve_nxt;
    logic               wr_q,       wr_nxt;
    logic [1:0]         size_q,     size_nxt;
    logic [ADDR_W-1:0]  addr_q,     addr_nxt;
    logic [DATA_W-1:0]  wdata_q,    wdata_nxt;
    logic               uncached_q, uncached_nxt;
    logic               inst_starved;
    logic               data_wins;

    // Fetch side never writes; its write-side fields and the core-side uncached are unused.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, inst.wr, inst.size, inst.wdata, inst.uncached, data.uncached};

    // Direct-mapped segments drop their top three bits; everything else passes through.
    function automatic logic [ADDR_W-1:0] translate(input logic [ADDR_W-1:0] va);
        logic [ADDR_W-1:0] pa;
        pa = va;
        if (va[31:30] == 2'b10) begin
            pa = {3'b000, va[28:0]};
        end
        return pa;
    endfunction

    // State, owner, starvation counter and latched transaction fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            uncached_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            wr_q       <= wr_nxt;
            size_q     <= size_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            uncached_q <= uncached_nxt;
        end
    end

    // Arbitration, next-state and the owner's pass-through handshakes.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        starve_nxt    = starve_cnt;
        wr_nxt        = wr_q;
        size_nxt      = size_q;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        uncached_nxt  = uncached_q;
        inst.addr_ok  = 1'b0;
        inst.data_ok  = 1'b0;
        data.addr_ok  = 1'b0;
        data.data_ok  = 1'b0;
        inst_starved  = inst.req && (starve_cnt == CNT_W'(STARVE_LIMIT));
        data_wins     = data.req && !inst_starved;

        case (state)
            S_IDLE: begin
                if (data_wins) begin
                    state_nxt    = S_REQ;
                    owner_nxt    = OWN_DATA;
                    wr_nxt       = data.wr;
                    size_nxt     = data.size;
                    addr_nxt     = translate(data.addr);
                    wdata_nxt    = data.wdata;
                    uncached_nxt = (data.addr[31:29] == 3'b101);
                    if (inst.req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                        starve_nxt = starve_cnt + CNT_W'(1);
                    end
                end else if (inst.req) begin
                    state_nxt    = S_REQ;
                    owner_nxt    = OWN_INST;
                    wr_nxt       = 1'b0;
                    size_nxt     = 2'd2;
                    addr_nxt     = translate(inst.addr);
                    wdata_nxt    = '0;
                    uncached_nxt = (inst.addr[31:29] == 3'b101);
                    starve_nxt   = '0;
                end
            end
            S_REQ: begin
                inst.addr_ok = (owner == OWN_INST) && bus.addr_ok;
                data.addr_ok = (owner == OWN_DATA) && bus.addr_ok;
                if (bus.addr_ok) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                inst.data_ok = (owner == OWN_INST) && bus.data_ok;
                data.data_ok = (owner == OWN_DATA) && bus.data_ok;
                if (bus.data_ok) begin
                    state_nxt = S_IDLE;
                    owner_nxt = OWN_NONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    // Bus side reflects the latched grant; read data fans out to both masters.
    assign bus.req      = (state == S_REQ);
    assign bus.wr       = wr_q;
    assign bus.size     = size_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.uncached = uncached_q;
    assign inst.rdata   = bus.rdata;
    assign data.rdata   = bus.rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized bench for sram_bus_arbiter against a transaction-level model.
module tb_sram_bus_arbiter;
    localparam int unsigned STARVE_LIMIT = 4;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_bus_arbiter_if inst_port ();
    sram_bus_arbiter_if data_port ();
    sram_bus_arbiter_if mem_port ();

    sram_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk  (clk),
        .rst  (rst),
        .inst (inst_port),
        .data (data_port),
        .bus  (mem_port)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned model_starve = 0;
    txn_t        iq[$];
    txn_t        dq[$];
    byte         glog[$];

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference address map: kseg0/kseg1 are windows onto physical 0..512MB.
    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    function automatic bit is_kseg1(input logic [31:0] va);
        return (va >= 32'hA000_0000) && (va < 32'hC000_0000);
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr    = 1'($urandom_range(1, 0));
        t.size  = 2'($urandom_range(2, 0));
        t.addr  = {3'($urandom_range(7, 0)), 29'($urandom)};
        t.wdata = $urandom;
        t.rdata = $urandom;
        return t;
    endfunction

    function automatic txn_t mk_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    // Present the head of each master's queue; fetch write-side fields are junk on purpose.
    task automatic drive_reqs();
        inst_port.req   = (iq.size() > 0);
        inst_port.addr  = (iq.size() > 0) ? iq[0].addr : 32'h0;
        inst_port.wr    = 1'($urandom_range(1, 0));
        inst_port.size  = 2'($urandom_range(3, 0));
        inst_port.wdata = $urandom;
        data_port.req   = (dq.size() > 0);
        if (dq.size() > 0) begin
            data_port.wr    = dq[0].wr;
            data_port.size  = dq[0].size;
            data_port.addr  = dq[0].addr;
            data_port.wdata = dq[0].wdata;
        end else begin
            data_port.wr    = 1'b0;
            data_port.size  = 2'd0;
            data_port.addr  = 32'h0;
            data_port.wdata = 32'h0;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_inst_aok"}, 32'(inst_port.addr_ok), 32'd0);
        check({tag, "_data_aok"}, 32'(data_port.addr_ok), 32'd0);
        check({tag, "_inst_dok"}, 32'(inst_port.data_ok), 32'd0);
        check({tag, "_data_dok"}, 32'(data_port.data_ok), 32'd0);
    endtask

    // Serve every queued transaction; the model picks each winner from the arbitration rules.
    task automatic run_batch(input int unsigned lat_max);
        int unsigned lat;
        int unsigned d;
        bit          ip, dp, win_data;
        txn_t        t;
        drive_reqs();
        while (iq.size() > 0 || dq.size() > 0) begin
            ip = (iq.size() > 0);
            dp = (dq.size() > 0);
            win_data = dp && !(ip && model_starve == STARVE_LIMIT);
            if (win_data) begin
                t = dq[0];
                if (ip && model_starve < STARVE_LIMIT) model_starve++;
            end else begin
                t = iq[0];
                t.wr = 1'b0; t.size = 2'd2; t.wdata = 32'h0;
                model_starve = 0;
            end

            lat = 0;
            while (mem_port.req !== 1'b1 && lat < 8) begin
                step();
                lat++;
            end
            check("req_latency", lat, 32'd1);
            check("bus_addr", mem_port.addr, phys(t.addr));
            check("bus_uncached", 32'(mem_port.uncached), 32'(is_kseg1(t.addr)));
            check("bus_wr", 32'(mem_port.wr), 32'(t.wr));
            check("bus_size", 32'(mem_port.size), 32'(t.size));
            check("bus_wdata", mem_port.wdata, t.wdata);

            d = $urandom_range(lat_max, 0);
            repeat (d) begin
                mem_port.data_ok = 1'($urandom_range(1, 0));
                mem_port.rdata   = $urandom;
                #1;
                check("req_hold", 32'(mem_port.req), 32'd1);
                check_quiet("addr_wait");
                step();
                mem_port.data_ok = 1'b0;
            end
            mem_port.addr_ok = 1'b1;
            mem_port.data_ok = 1'($urandom_range(1, 0));
            #1;
            check("inst_aok", 32'(inst_port.addr_ok), 32'(!win_data));
            check("data_aok", 32'(data_port.addr_ok), 32'(win_data));
            check("req_inst_dok", 32'(inst_port.data_ok), 32'd0);
            check("req_data_dok", 32'(data_port.data_ok), 32'd0);
            step();
            mem_port.addr_ok = 1'b0;
            mem_port.data_ok = 1'b0;

            if (win_data) dq.delete(0);
            else          iq.delete(0);
            glog.push_back(win_data ? "D" : "I");
            drive_reqs();

            d = $urandom_range(lat_max, 0);
            repeat (d) begin
                mem_port.addr_ok = 1'($urandom_range(1, 0));
                #1;
                check("data_req_low", 32'(mem_port.req), 32'd0);
                check_quiet("data_wait");
                step();
                mem_port.addr_ok = 1'b0;
            end
            mem_port.data_ok = 1'b1;
            mem_port.rdata   = t.rdata;
            #1;
            check("inst_dok", 32'(inst_port.data_ok), 32'(!win_data));
            check("data_dok", 32'(data_port.data_ok), 32'(win_data));
            check(win_data ? "data_rdata" : "inst_rdata",
                  win_data ? data_port.rdata : inst_port.rdata, t.rdata);
            check("dok_inst_aok", 32'(inst_port.addr_ok), 32'd0);
            check("dok_data_aok", 32'(data_port.addr_ok), 32'd0);
            step();
            mem_port.data_ok = 1'b0;
            mem_port.rdata   = $urandom;
        end
        #1;
        check("idle_req_low", 32'(mem_port.req), 32'd0);
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(mem_port.req), 32'd0);
        check({tag, "_wr"}, 32'(mem_port.wr), 32'd0);
        check({tag, "_size"}, 32'(mem_port.size), 32'd0);
        check({tag, "_addr"}, mem_port.addr, 32'd0);
        check({tag, "_wdata"}, mem_port.wdata, 32'd0);
        check({tag, "_uncached"}, 32'(mem_port.uncached), 32'd0);
        check_quiet(tag);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_starve = 0;
        step();
    endtask

    // Reset while DATA is outstanding; a late bus ack must be swallowed.
    task automatic reset_mid_txn();
        int unsigned lat;
        dq.push_back(mk_txn(1'b0, 2'd2, 32'hA000_2000, 32'h0, 32'h1234_5678));
        drive_reqs();
        lat = 0;
        while (mem_port.req !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        check("rst_req_latency", lat, 32'd1);
        mem_port.addr_ok = 1'b1;
        step();
        mem_port.addr_ok = 1'b0;
        dq.delete(0);
        drive_reqs();
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        step();
        rst = 1'b0;
        model_starve = 0;
        mem_port.data_ok = 1'b1;
        mem_port.rdata   = 32'h1234_5678;
        #1;
        check("late_inst_dok", 32'(inst_port.data_ok), 32'd0);
        check("late_data_dok", 32'(data_port.data_ok), 32'd0);
        step();
        mem_port.data_ok = 1'b0;
        #1;
        check("post_rst_req", 32'(mem_port.req), 32'd0);
        step();
    endtask

    initial begin
        string exp_order;
        int unsigned ni, nd;

        rst = 1'b1;
        inst_port.req = 1'b0; inst_port.wr = 1'b0; inst_port.size = 2'd0;
        inst_port.addr = 32'h0; inst_port.wdata = 32'h0; inst_port.uncached = 1'b0;
        data_port.req = 1'b0; data_port.wr = 1'b0; data_port.size = 2'd0;
        data_port.addr = 32'h0; data_port.wdata = 32'h0; data_port.uncached = 1'b0;
        mem_port.addr_ok = 1'b0; mem_port.data_ok = 1'b0; mem_port.rdata = 32'h0;
        step();
        mem_port.data_ok = 1'b1;
        step();
        check_all_zero("reset");
        mem_port.data_ok = 1'b0;
        rst = 1'b0;
        step();

        // Boot fetch from kseg1.
        iq.push_back(mk_txn(1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h2408_0001));
        run_batch(1);

        // Cached data write, then pass-through segments from both ports at once.
        dq.push_back(mk_txn(1'b1, 2'd2, 32'h8000_1004, 32'hDEAD_BEEF, 32'h0));
        run_batch(1);
        dq.push_back(mk_txn(1'b0, 2'd0, 32'h0040_0000, 32'h0, 32'h55AA_0102));
        iq.push_back(mk_txn(1'b0, 2'd2, 32'hC000_0000, 32'h0, 32'h0BAD_F00D));
        run_batch(2);

        // Starvation relief with both ports saturated on a single-cycle bus.
        apply_reset();
        repeat (2) iq.push_back(rand_txn());
        repeat (8) dq.push_back(rand_txn());
        glog.delete();
        run_batch(0);
        exp_order = "DDDDIDDDDI";
        check("grant_count", glog.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("grant_%0d", i), 32'(glog[i]), 32'(exp_order[i]));
        end

        reset_mid_txn();
        dq.push_back(mk_txn(1'b1, 2'd1, 32'h0000_0100, 32'hCAFE_0001, 32'h0));
        run_batch(1);

        // Random mixes of fetch and data traffic with variable bus latency.
        repeat (40) begin
            ni = $urandom_range(3, 0);
            nd = $urandom_range(4, 0);
            repeat (ni) iq.push_back(rand_txn());
            repeat (nd) dq.push_back(rand_txn());
            run_batch(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port and the data port of the CPU core. Read-only inst; read/write data.
- Fixed-direct-map translation: kseg0 (0x8000_0000–0x9FFF_FFFF) and kseg1 (0xA000_0000–0xBFFF_FFFF) lose bits [31:29]. All other segments pass unchanged.
- One outstanding transaction at a time. Sits between the core's two SRAM-like master ports and the bus bridge.

Parameters:
- STARVE_LIMIT, 4, max consecutive data grants while inst_req is pending before inst is forced to win (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch virtual address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  data request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data virtual address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data read returned / write done
- data_rdata  out  32  read data
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus size
- bus_addr  out  32  physical address
- bus_wdata  out  32  bus write data
- bus_uncached  out  1  1 when the granted address is in kseg1
- bus_addr_ok  in  1  bus address accepted
- bus_data_ok  in  1  bus data/ack
- bus_rdata  in  32  bus read data

Behaviour:
- Reset state:
  - state = IDLE; owner = none; starve_cnt = 0.
  - Latched wr/size/addr/wdata/uncached = 0.
  - bus_req = 0; all *_addr_ok and *_data_ok = 0.
- Masters hold req and their fields stable until their addr_ok (SRAM-like rule).
- State IDLE (bus_req = 0):
  - Any req pending: choose winner, latch translated fields and owner, go to REQ.
  - bus_req rises the cycle after the req is first sampled. Minimum latency: 1 cycle.
- Arbitration (evaluated only in IDLE):
  - Data wins over inst, except when inst_req = 1 and starve_cnt == STARVE_LIMIT; then inst wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) on a data grant while inst_req = 1.
  - starve_cnt clears to 0 on an inst grant. It is unchanged on a data grant while inst_req = 0.
- Inst grant drives: wr = 0, size = 2, wdata = 0.
- State REQ (bus_req = 1, bus_* = latched values):
  - Owner's addr_ok = bus_addr_ok, combinational, one cycle only.
  - On bus_addr_ok, go to DATA.
- State DATA (bus_req = 0):
  - Owner's data_ok = bus_data_ok, combinational.
  - On bus_data_ok, go to IDLE. The next grant can start in that IDLE cycle, so bus_req reasserts 2 cycles after data_ok.
- Outside DATA: bus_data_ok is ignored, and no data_ok reaches either master.
- The non-owner's addr_ok and data_ok stay 0 at all times.
- inst_rdata = data_rdata = bus_rdata at all times. Valid only while the matching data_ok is high.
- Translation:
  - Bits [31:29] = 100 or 101: set them to 000.
  - Otherwise: address unchanged.
  - bus_uncached = (va[31:29] == 101).
- Simultaneous inst_req and data_req in IDLE: one grant only. The loser keeps req high and is served after the winner's data_ok.
- Reset mid-transaction: return to IDLE immediately and drop bus_req. A late bus_data_ok is ignored.

Test Plan:
- Single fetch, inst_addr = 0xBFC0_0000:
  - bus_req rises 1 cycle later, with bus_addr = 0x1FC0_0000, bus_uncached = 1, bus_wr = 0, bus_size = 2.
  - bus_addr_ok drives inst_addr_ok; bus_data_ok with rdata 0x2408_0001 drives inst_data_ok and inst_rdata = 0x2408_0001.
- Data write, data_addr = 0x8000_1004, wdata = 0xDEAD_BEEF, size = 2:
  - bus_addr = 0x0000_1004, bus_uncached = 0, bus_wr = 1, bus_wdata = 0xDEAD_BEEF.
  - data_data_ok on the ack; inst_* oks stay 0.
- Kuseg/kseg2 pass-through: 0x0040_0000 and 0xC000_0000 appear unchanged on bus_addr, with bus_uncached = 0.
- Simultaneous inst_req and data_req held continuously, STARVE_LIMIT = 4, single-cycle bus:
  - Grant order: D, D, D, D, I, D, D, D, D, I.
  - starve_cnt returns to 0 after each inst grant.
- Back-to-back: data_req asserted during DATA with bus_data_ok:
  - Next bus_req exactly 2 cycles after that data_ok.
  - A bus_data_ok pulse injected in REQ produces no master data_ok.
- rst asserted in DATA, then bus_data_ok the following cycle:
  - All outputs 0, state IDLE, no data_ok forwarded.
  - The next request after rst is released is served normally.
